button_debounce_array: RTL
==========================

# button_debounce_array

Parametrised multi-channel successor to the single-button debouncer. Each of `CHANNELS` raw push-button inputs is synchronised and debounced against a programmable stability window. The block produces, per channel:
- a clean level;
- one-cycle press and release pulses;
- a one-shot long-press pulse.

It sits between the board pushbuttons and the user-facing control logic. All outputs are registered in the single `clock` domain.

## Interface
- `CHANNELS`, 4: number of independent button channels (≥1)
- `SYNC_STAGES`, 2: synchroniser flops per channel (≥2)
- `STABLE_CYCLES`, 4: consecutive cycles a new input level must persist before it is accepted (≥1)
- `LONG_CYCLES`, 500: cycles after a press before `long_press` fires (>`STABLE_CYCLES`)
- `ACTIVE_LOW`, 0: 1 = raw input is low when pressed; the input is inverted before the synchroniser
- `clock` in 1: system clock; all state updates on the rising edge
- `reset` in 1: synchronous, active-high reset
- `button` in `CHANNELS`: raw asynchronous button inputs
- `btn_opt` out `CHANNELS`: debounced pressed level, 1 = pressed
- `press_pulse` out `CHANNELS`: one-cycle pulse when `btn_opt` rises
- `release_pulse` out `CHANNELS`: one-cycle pulse when `btn_opt` falls
- `long_press` out `CHANNELS`: one-cycle pulse, at most once per press

## Operation
Channels are fully independent. Per channel:
- **Input path.** `p = button ^ ACTIVE_LOW` feeds a `SYNC_STAGES`-deep flop chain. The last stage is `s`.
- **Stability counter.** `dcnt`, width `$clog2(STABLE_CYCLES+1)`.
  - If `s == btn_opt`: `dcnt` ← 0.
  - Else if `dcnt == STABLE_CYCLES-1`: `btn_opt` ← `s`, `dcnt` ← 0.
  - Else: `dcnt` ← `dcnt+1`.
  - Any cycle of agreement during the window restarts it, so glitches shorter than `STABLE_CYCLES` cycles are rejected.
- **Edge pulses.** `press_pulse`/`release_pulse` are registered and asserted on the same edge `btn_opt` changes. They are high for exactly one cycle and are never both high.
- **Hold counter.** `hcnt`, width `$clog2(LONG_CYCLES+1)`.
  - Cleared on the edge `btn_opt` rises.
  - While `btn_opt` is 1 and `hcnt < LONG_CYCLES`, it increments each cycle.
  - It saturates at `LONG_CYCLES`.
  - `long_press` pulses on the edge `hcnt` becomes `LONG_CYCLES`.
  - Cleared when `btn_opt` is 0. Release before expiry means no `long_press`.
- **No wrap-around.** Both counters are bounded by compare; neither can overflow.

## Timing
- **Reset state.** On an edge with `reset`=1:
  - all sync flops, `dcnt`, `hcnt` = 0;
  - `btn_opt`, `press_pulse`, `release_pulse`, `long_press` = 0.
- **Reset mid-operation.** Discards a pending debounce window and a pending long-press. After reset, a button still held is re-detected with full latency.
- **Debounce latency.** Count the first rising edge that samples a new stable `p` as edge 1. `btn_opt` and the edge pulse update on edge `SYNC_STAGES+STABLE_CYCLES`; with defaults that is edge 6.
- **Long-press latency.** If `press_pulse` is high after edge e, `long_press` is high after edge e+`LONG_CYCLES` (one cycle), provided `btn_opt` stayed 1 throughout.
- **Simultaneous release.** If release is accepted on the same edge `hcnt` would reach `LONG_CYCLES`, release wins: `release_pulse`=1, `long_press`=0.
- **STABLE_CYCLES=1.** Any synchronised change is accepted on the next edge.
- **Channel independence.** Simultaneous events on different channels have no interaction.

## Structure
- **Shared package `button_pkg`.** Holds:
  - default parameter constants (`BTN_SYNC_STAGES`, `BTN_STABLE_CYCLES`, `BTN_LONG_CYCLES`);
  - a width helper, `btn_cnt_w(max)`, returning `$clog2(max+1)`.
- **Sub-module `button_debounce_channel`.**
  - Contains the synchroniser, `dcnt`, `hcnt` and pulse registers for one bit.
  - The top level is a generate loop instantiating it `CHANNELS` times.
  - The top level also holds elaboration-time parameter-legality checks.

## Test plan
Bench configuration: `CHANNELS`=2, `SYNC_STAGES`=2, `STABLE_CYCLES`=4, `LONG_CYCLES`=10, `ACTIVE_LOW`=0.
- **Reset.** Hold `reset` 3 cycles with `button`=2'b11 → all outputs 0 during reset. `btn_opt`=2'b11 and `press_pulse`=2'b11 appear on edge 6 after reset release, for one cycle.
- **Glitch rejection.** `button[0]` high for 3 cycles, then low → `btn_opt[0]` and all pulses stay 0. Then high for 4+ cycles → `btn_opt[0]`=1 on edge 6 with `press_pulse[0]`.
- **Bounce.** `button[1]` toggles 1,0,1,1,0,1 per cycle, then holds 1 → no output until 4 stable synced cycles. Exactly one `press_pulse[1]`.
- **Long press.** Hold `button[0]`=1 for 30 cycles → `long_press[0]` exactly once, 10 cycles after `press_pulse[0]`. Then release → one `release_pulse[0]`, no further `long_press`.
- **Short press.** Press held so `btn_opt`=1 for 7 cycles → `release_pulse[0]`, `long_press[0]` never asserted. Repeat with release accepted on the `hcnt`=10 edge → `release_pulse`=1, `long_press`=0.
- **ACTIVE_LOW=1 and independence.**
  - Idle `button`=2'b11 → outputs 0. Drive `button[1]`=0 → `btn_opt`=2'b10.
  - Independence: ch0 press and ch1 release applied on the same cycle → both pulses fire on the same edge, no crosstalk.

Source files
------------

// File: rtl/button_pkg.sv
// -----------------------------------------------------------------------------
// button_pkg
// Shared constants and helpers for the push-button debounce array.
//   BTN_SYNC_STAGES   : default synchroniser depth per channel
//   BTN_STABLE_CYCLES : default stability window in clock cycles
//   BTN_LONG_CYCLES   : default hold time before a long-press pulse
//   btn_cnt_w(max)    : bit width needed for a counter that reaches 'max'
// -----------------------------------------------------------------------------
package button_pkg;

    localparam int BTN_SYNC_STAGES   = 32'sd2;
    localparam int BTN_STABLE_CYCLES = 32'sd4;
    localparam int BTN_LONG_CYCLES   = 32'sd500;

    function automatic int btn_cnt_w(input int max_val);
        return $clog2(max_val + 32'sd1);
    endfunction

endpackage

// File: rtl/button_debounce_channel.sv
// -----------------------------------------------------------------------------
// button_debounce_channel
// One push-button channel: polarity fix, synchroniser, stability counter,
// edge pulses and a one-shot long-press detector. All outputs are registered.
// Ports:
//   clock         : system clock, rising edge
//   reset         : synchronous active-high reset
//   button        : raw asynchronous button level
//   btn_opt       : debounced level, 1 = pressed
//   press_pulse   : one cycle when btn_opt rises
//   release_pulse : one cycle when btn_opt falls
//   long_press    : one cycle when the press has lasted LONG_CYCLES cycles
// -----------------------------------------------------------------------------
module button_debounce_channel
    import button_pkg::*;
#(
    parameter int SYNC_STAGES   = BTN_SYNC_STAGES,
    parameter int STABLE_CYCLES = BTN_STABLE_CYCLES,
    parameter int LONG_CYCLES   = BTN_LONG_CYCLES,
    parameter bit ACTIVE_LOW    = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic button,
    output logic btn_opt,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press
);

    localparam int DW = btn_cnt_w(STABLE_CYCLES);
    localparam int HW = btn_cnt_w(LONG_CYCLES);
    localparam logic [DW-1:0] DCNT_LAST = DW'(STABLE_CYCLES - 32'sd1);
    localparam logic [HW-1:0] HCNT_MAX  = HW'(LONG_CYCLES);
    localparam logic [HW-1:0] HCNT_PRE  = HW'(LONG_CYCLES - 32'sd1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [DW-1:0]          dcnt_q, dcnt_d;
    logic [HW-1:0]          hcnt_q, hcnt_d;
    logic                   btn_q, btn_d;
    logic                   press_q, press_d;
    logic                   rel_q, rel_d;
    logic                   long_q, long_d;
    logic                   samp_s;
    logic                   accept_s;

    // Next-state logic: synchroniser shift, stability window, pulses, hold timer.
    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], button ^ ACTIVE_LOW};
        samp_s   = sync_q[SYNC_STAGES-1];
        accept_s = 1'b0;
        btn_d    = btn_q;
        dcnt_d   = dcnt_q;
        hcnt_d   = hcnt_q;
        long_d   = 1'b0;

        // Any cycle of agreement restarts the window; a full window of
        // disagreement flips the debounced level.
        if (samp_s == btn_q) begin
            dcnt_d = {DW{1'b0}};
        end else if (dcnt_q == DCNT_LAST) begin
            accept_s = 1'b1;
            btn_d    = samp_s;
            dcnt_d   = {DW{1'b0}};
        end else begin
            dcnt_d = dcnt_q + DW'(1'b1);
        end

        press_d = accept_s & samp_s;
        rel_d   = accept_s & ~samp_s;

        // A release accepted on the expiry edge suppresses long_press, because
        // the hold branch is only taken while no release is being accepted.
        if (press_d) begin
            hcnt_d = {HW{1'b0}};
        end else if (btn_q && !rel_d) begin
            if (hcnt_q < HCNT_MAX) begin
                hcnt_d = hcnt_q + HW'(1'b1);
                long_d = (hcnt_q == HCNT_PRE);
            end else begin
                hcnt_d = hcnt_q;
            end
        end else begin
            hcnt_d = {HW{1'b0}};
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q  <= {SYNC_STAGES{1'b0}};
            dcnt_q  <= {DW{1'b0}};
            hcnt_q  <= {HW{1'b0}};
            btn_q   <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            long_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            dcnt_q  <= dcnt_d;
            hcnt_q  <= hcnt_d;
            btn_q   <= btn_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            long_q  <= long_d;
        end
    end

    assign btn_opt       = btn_q;
    assign press_pulse   = press_q;
    assign release_pulse = rel_q;
    assign long_press    = long_q;

endmodule

// File: rtl/button_debounce_array.sv
// -----------------------------------------------------------------------------
// button_debounce_array
// CHANNELS independent debounced push-button channels.
// Ports:
//   clock         : system clock, rising edge
//   reset         : synchronous active-high reset
//   button        : raw asynchronous button inputs
//   btn_opt       : debounced pressed levels
//   press_pulse   : one-cycle pulses on debounced press
//   release_pulse : one-cycle pulses on debounced release
//   long_press    : one-shot pulses after LONG_CYCLES of continuous press
// -----------------------------------------------------------------------------
module button_debounce_array
    import button_pkg::*;
#(
    parameter int CHANNELS      = 32'sd4,
    parameter int SYNC_STAGES   = BTN_SYNC_STAGES,
    parameter int STABLE_CYCLES = BTN_STABLE_CYCLES,
    parameter int LONG_CYCLES   = BTN_LONG_CYCLES,
    parameter bit ACTIVE_LOW    = 1'b0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CHANNELS-1:0] button,
    output logic [CHANNELS-1:0] btn_opt,
    output logic [CHANNELS-1:0] press_pulse,
    output logic [CHANNELS-1:0] release_pulse,
    output logic [CHANNELS-1:0] long_press
);

    // Parameter legality, resolved at elaboration.
    if (CHANNELS < 32'sd1) begin : g_bad_channels
        $error("button_debounce_array: CHANNELS must be >= 1");
    end
    if (SYNC_STAGES < 32'sd2) begin : g_bad_sync
        $error("button_debounce_array: SYNC_STAGES must be >= 2");
    end
    if (STABLE_CYCLES < 32'sd1) begin : g_bad_stable
        $error("button_debounce_array: STABLE_CYCLES must be >= 1");
    end
    if (LONG_CYCLES <= STABLE_CYCLES) begin : g_bad_long
        $error("button_debounce_array: LONG_CYCLES must exceed STABLE_CYCLES");
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        button_debounce_channel #(
            .SYNC_STAGES  (SYNC_STAGES),
            .STABLE_CYCLES(STABLE_CYCLES),
            .LONG_CYCLES  (LONG_CYCLES),
            .ACTIVE_LOW   (ACTIVE_LOW)
        ) u_ch (
            .clock        (clock),
            .reset        (reset),
            .button       (button[i]),
            .btn_opt      (btn_opt[i]),
            .press_pulse  (press_pulse[i]),
            .release_pulse(release_pulse[i]),
            .long_press   (long_press[i])
        );
    end

endmodule
